// File: rtl/dmac_config_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmac_config_ctrl_if
//   Bundle of every signal between the DMAC config sequencer and the rest of
//   the DMAC: peripheral request, AHB fetch handshake, descriptor capture
//   enables, master-port mux select and channel run enables.
//
//   master : seen from dmac_config_ctrl (drives enables/selects, reads
//            request, AHB response, channel select and irq)
//   slave  : seen from the datapath / AHB side (the mirror image)
// ---------------------------------------------------------------------------
interface dmac_config_ctrl_if;
  logic [1:0] DmacReq;
  logic       HReady;
  logic [1:0] M_HResp;
  logic       C_config;
  logic       irq;

  logic       DmacReq_Reg_en;
  logic       PeriAddr_reg_en;
  logic       SAddr_Reg_en;
  logic       DAddr_Reg_en;
  logic       Trans_sz_Reg_en;
  logic       Ctrl_Reg_en;
  logic [1:0] addr_inc_sel;
  logic [1:0] config_HTrans;
  logic       config_write;
  logic [1:0] con_sel;
  logic       con_en;
  logic       channel_en_1;
  logic       channel_en_2;
  logic       busy;
  logic       cfg_err;

  modport master (
    input  DmacReq, HReady, M_HResp, C_config, irq,
    output DmacReq_Reg_en, PeriAddr_reg_en, SAddr_Reg_en, DAddr_Reg_en,
           Trans_sz_Reg_en, Ctrl_Reg_en, addr_inc_sel, config_HTrans,
           config_write, con_sel, con_en, channel_en_1, channel_en_2,
           busy, cfg_err
  );

  modport slave (
    output DmacReq, HReady, M_HResp, C_config, irq,
    input  DmacReq_Reg_en, PeriAddr_reg_en, SAddr_Reg_en, DAddr_Reg_en,
           Trans_sz_Reg_en, Ctrl_Reg_en, addr_inc_sel, config_HTrans,
           config_write, con_sel, con_en, channel_en_1, channel_en_2,
           busy, cfg_err
  );
endinterface

// File: rtl/dmac_config_ctrl.sv
// ---------------------------------------------------------------------------
// dmac_config_ctrl
//   Control sequencer for the two-channel DMAC. On a peripheral request it
//   latches the request, fetches the four-word descriptor over the AHB
//   master port (pipelined address/data phases), arms the channel chosen by
//   the descriptor and holds it running until the transfer-complete irq.
//
//   clk : system clock, rising edge
//   rst : asynchronous reset, active low
//   bus : dmac_config_ctrl_if.master (request, AHB handshake, capture
//         enables, mux select, channel enables, status)
// ---------------------------------------------------------------------------
module dmac_config_ctrl (
  input  logic                   clk,
  input  logic                   rst,
  dmac_config_ctrl_if.master     bus
);

  typedef enum logic [2:0] {IDLE, LATCH, FETCH, ARM, XFER, DONE} state_t;

  state_t     state, next_state;
  logic [2:0] acnt, dcnt;
  logic [2:0] acnt_next, dcnt_next;
  logic [1:0] con_sel_q, con_sel_prev;
  logic       ch1_q, ch2_q, busy_q;

  logic       addr_phase;
  logic       data_pend;
  logic       resp_err;
  logic       capture;

  // acnt counts address beats issued, dcnt data beats captured; a data beat
  // is outstanding whenever more addresses have gone out than words came in.
  assign addr_phase = (state == FETCH) && !acnt[2];
  assign data_pend  = (state == FETCH) && (acnt > dcnt);
  assign resp_err   = data_pend && (bus.M_HResp != 2'b00);
  assign capture    = data_pend && bus.HReady && (bus.M_HResp == 2'b00);

  // Next-state and counter logic. The move to ARM happens on the capture of
  // the fourth word so the fetch takes 4 address beats plus 1 trailing beat.
  always_comb begin
    next_state = state;
    acnt_next  = acnt;
    dcnt_next  = dcnt;
    case (state)
      IDLE:  if (bus.DmacReq != 2'b00) next_state = LATCH;
      LATCH: next_state = FETCH;
      FETCH: begin
        if (resp_err) begin
          next_state = IDLE;
        end else begin
          if (addr_phase && bus.HReady) acnt_next = acnt + 3'd1;
          if (capture) begin
            dcnt_next = dcnt + 3'd1;
            if (dcnt == 3'd3) next_state = ARM;
          end
        end
      end
      ARM:   next_state = XFER;
      XFER:  if (bus.irq) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (next_state != FETCH) begin
      acnt_next = 3'd0;
      dcnt_next = 3'd0;
    end
  end

  // State, counters and the registered outputs. con_sel and the channel
  // enables are loaded from the next state so they are valid in the very
  // cycle of ARM/XFER/DONE; con_sel_prev lets con_en flag every change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      acnt         <= 3'd0;
      dcnt         <= 3'd0;
      con_sel_q    <= 2'b10;
      con_sel_prev <= 2'b10;
      ch1_q        <= 1'b0;
      ch2_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state        <= next_state;
      acnt         <= acnt_next;
      dcnt         <= dcnt_next;
      con_sel_prev <= con_sel_q;
      busy_q       <= (next_state != IDLE);
      case (next_state)
        ARM:     con_sel_q <= {1'b0, bus.C_config};
        XFER:    con_sel_q <= con_sel_q;
        default: con_sel_q <= 2'b10;
      endcase
      if (next_state == XFER) begin
        if (state == ARM) begin
          ch1_q <= !bus.C_config;
          ch2_q <= bus.C_config;
        end
      end else begin
        ch1_q <= 1'b0;
        ch2_q <= 1'b0;
      end
    end
  end

  // Combinational strobes for the datapath; only one descriptor word can be
  // captured per cycle because capture selects exactly one dcnt index.
  always_comb begin
    bus.DmacReq_Reg_en  = (state == LATCH);
    bus.PeriAddr_reg_en = (state == LATCH);
    bus.SAddr_Reg_en    = capture && (dcnt[1:0] == 2'd0);
    bus.DAddr_Reg_en    = capture && (dcnt[1:0] == 2'd1);
    bus.Trans_sz_Reg_en = capture && (dcnt[1:0] == 2'd2);
    bus.Ctrl_Reg_en     = capture && (dcnt[1:0] == 2'd3);
    bus.config_HTrans   = addr_phase ? 2'b10 : 2'b00;
    bus.addr_inc_sel    = addr_phase ? acnt[1:0] : 2'b00;
    bus.config_write    = 1'b0;
    bus.cfg_err         = resp_err;
    bus.con_sel         = con_sel_q;
    bus.con_en          = (con_sel_q != con_sel_prev);
    bus.channel_en_1    = ch1_q;
    bus.channel_en_2    = ch2_q;
    bus.busy            = busy_q;
  end

endmodule

// File: tb/tb_dmac_config_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmac_config_ctrl
//   Directed scenarios followed by random traffic for dmac_config_ctrl.
//   Inputs change on the falling edge; outputs are sampled 1 ns before the
//   next rising edge.
// ---------------------------------------------------------------------------
module tb_dmac_config_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_LATCH = 1;
  localparam int M_FETCH = 2;
  localparam int M_ARM   = 3;
  localparam int M_XFER  = 4;
  localparam int M_DONE  = 5;

  logic clk = 1'b0;
  logic rst;

  dmac_config_ctrl_if bus ();

  dmac_config_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase of the sequencer plus descriptor beat counts.
  int         m_state  = M_IDLE;
  int         issued   = 0;
  int         captured = 0;
  logic       m_chan   = 1'b0;
  logic [1:0] prev_sel = 2'b10;

  // Per-transaction recorders used by the directed scenarios.
  int en_first [4];
  int addr_at  [64];
  int sel_at   [64];
  int busy_at  [64];
  int ch1_first, ch2_first, ch1_high, ch2_high, con_en_count, err_count;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic hready,
                               input logic [1:0] hresp, input logic cconf,
                               input logic irq_in);
    @(negedge clk);
    bus.DmacReq  = req;
    bus.HReady   = hready;
    bus.M_HResp  = hresp;
    bus.C_config = cconf;
    bus.irq      = irq_in;
    #4;
  endtask

  // Cycle compare: expected outputs derived from the model phase and beat
  // counts, then the model advances by one clock.
  always begin
    logic [1:0] e_sel;
    logic       addr_ph, pend, err, cap;
    int         e_cap;
    @(negedge clk);
    #4;
    if (rst !== 1'b1) begin
      m_state  = M_IDLE;
      issued   = 0;
      captured = 0;
      prev_sel = 2'b10;
    end
    addr_ph = (m_state == M_FETCH) && (issued < 4);
    pend    = (m_state == M_FETCH) && (issued > captured);
    err     = pend && (bus.M_HResp != 2'b00);
    cap     = pend && bus.HReady && (bus.M_HResp == 2'b00);
    e_cap   = cap ? (1 << captured) : 0;
    e_sel   = (m_state == M_ARM || m_state == M_XFER) ? {1'b0, m_chan} : 2'b10;

    checkOutput("busy", 32'(bus.busy), 32'(m_state != M_IDLE));
    checkOutput("latch_en", 32'({bus.DmacReq_Reg_en, bus.PeriAddr_reg_en}),
                (m_state == M_LATCH) ? 3 : 0);
    checkOutput("capture_en", 32'({bus.Ctrl_Reg_en, bus.Trans_sz_Reg_en,
                bus.DAddr_Reg_en, bus.SAddr_Reg_en}), e_cap);
    checkOutput("htrans", 32'(bus.config_HTrans), addr_ph ? 2 : 0);
    checkOutput("addr_inc_sel", 32'(bus.addr_inc_sel), addr_ph ? issued : 0);
    checkOutput("config_write", 32'(bus.config_write), 0);
    checkOutput("cfg_err", 32'(bus.cfg_err), 32'(err));
    checkOutput("con_sel", 32'(bus.con_sel), 32'(e_sel));
    checkOutput("con_en", 32'(bus.con_en), 32'(e_sel != prev_sel));
    checkOutput("channel_en_1", 32'(bus.channel_en_1),
                32'(m_state == M_XFER && !m_chan));
    checkOutput("channel_en_2", 32'(bus.channel_en_2),
                32'(m_state == M_XFER && m_chan));

    if (rst === 1'b1) begin
      prev_sel = e_sel;
      case (m_state)
        M_IDLE:  if (bus.DmacReq != 2'b00) m_state = M_LATCH;
        M_LATCH: begin
          m_state  = M_FETCH;
          issued   = 0;
          captured = 0;
        end
        M_FETCH: begin
          if (err) begin
            m_state = M_IDLE;
          end else begin
            if (cap) captured++;
            if (addr_ph && bus.HReady) issued++;
            if (captured == 4) begin
              m_state = M_ARM;
              m_chan  = bus.C_config;
            end
          end
        end
        M_ARM:   m_state = M_XFER;
        M_XFER:  if (bus.irq) m_state = M_DONE;
        default: m_state = M_IDLE;
      endcase
    end
  end

  // Runs n sampled cycles of one request, optionally stalling HReady over
  // [stall_from, stall_to] and injecting an error response at err_at.
  task automatic runTxn(input logic [1:0] req, input logic cconf,
                        input int stall_from, input int stall_to,
                        input int err_at, input int n);
    for (int i = 0; i < 4; i++) en_first[i] = -1;
    ch1_first = -1; ch2_first = -1; ch1_high = 0; ch2_high = 0;
    con_en_count = 0; err_count = 0;
    for (int k = 1; k <= n; k++) begin
      applyStimulus((err_at > 0 && k > err_at) ? 2'b00 : req,
                    (k >= stall_from && k <= stall_to) ? 1'b0 : 1'b1,
                    (k == err_at) ? 2'b01 : 2'b00, cconf, 1'b0);
      addr_at[k] = (bus.config_HTrans == 2'b10) ? int'(bus.addr_inc_sel) : -1;
      sel_at[k]  = int'(bus.con_sel);
      busy_at[k] = int'(bus.busy);
      if (bus.SAddr_Reg_en    && en_first[0] < 0) en_first[0] = k;
      if (bus.DAddr_Reg_en    && en_first[1] < 0) en_first[1] = k;
      if (bus.Trans_sz_Reg_en && en_first[2] < 0) en_first[2] = k;
      if (bus.Ctrl_Reg_en     && en_first[3] < 0) en_first[3] = k;
      if (bus.channel_en_1 && ch1_first < 0) ch1_first = k;
      if (bus.channel_en_2 && ch2_first < 0) ch2_first = k;
      ch1_high     += int'(bus.channel_en_1);
      ch2_high     += int'(bus.channel_en_2);
      con_en_count += int'(bus.con_en);
      err_count    += int'(bus.cfg_err);
    end
  endtask

  // From XFER: raise irq for one cycle, then check DONE and the IDLE return.
  task automatic drainTxn(input logic [1:0] req_after, input logic cconf);
    applyStimulus(req_after, 1'b1, 2'b00, cconf, 1'b1);
    applyStimulus(req_after, 1'b1, 2'b00, cconf, 1'b0);
    checkOutput("done_channels", 32'({bus.channel_en_2, bus.channel_en_1}), 0);
    checkOutput("done_con_sel", 32'(bus.con_sel), 2);
    checkOutput("done_con_en", 32'(bus.con_en), 1);
    checkOutput("done_busy", 32'(bus.busy), 1);
    applyStimulus(req_after, 1'b1, 2'b00, cconf, 1'b0);
    checkOutput("idle_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    int         hold;
    logic [1:0] req;
    logic       cc;

    rst          = 1'b0;
    bus.DmacReq  = 2'b00;
    bus.HReady   = 1'b1;
    bus.M_HResp  = 2'b00;
    bus.C_config = 1'b0;
    bus.irq      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 0);
    checkOutput("reset_con_sel", 32'(bus.con_sel), 2);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(2'b00, 1'b1, 2'b00, 1'b0, 1'b0);

    // Nominal fetch, channel 1.
    $display("[TB] nominal fetch, channel 1");
    runTxn(2'b01, 1'b0, 0, 0, 0, 14);
    checkOutput("t1_addr_seq", 32'({addr_at[3][1:0], addr_at[4][1:0],
                addr_at[5][1:0], addr_at[6][1:0]}), 32'h1b);
    checkOutput("t1_addr_after", 32'(addr_at[7]), 32'(-1));
    checkOutput("t1_saddr", en_first[0], 4);
    checkOutput("t1_daddr", en_first[1], 5);
    checkOutput("t1_transsz", en_first[2], 6);
    checkOutput("t1_ctrl", en_first[3], 7);
    checkOutput("t1_ch1_rise", ch1_first, 9);
    checkOutput("t1_ch2_never", ch2_first, 32'(-1));
    checkOutput("t1_con_en_count", con_en_count, 1);
    drainTxn(2'b00, 1'b0);

    // HReady stalled for two cycles while word 1 is addressed.
    $display("[TB] two-cycle stall on word 1");
    runTxn(2'b01, 1'b0, 4, 5, 0, 16);
    checkOutput("t2_addr_hold", 32'({addr_at[4][1:0], addr_at[5][1:0],
                addr_at[6][1:0]}), 32'h15);
    checkOutput("t2_saddr", en_first[0], 6);
    checkOutput("t2_daddr", en_first[1], 7);
    checkOutput("t2_ch1_rise", ch1_first, 11);
    drainTxn(2'b00, 1'b0);

    // Error response on the word-2 data phase.
    $display("[TB] error on word 2");
    runTxn(2'b01, 1'b0, 0, 0, 6, 12);
    checkOutput("t3_err_count", err_count, 1);
    checkOutput("t3_daddr", en_first[1], 5);
    checkOutput("t3_transsz_never", en_first[2], 32'(-1));
    checkOutput("t3_ctrl_never", en_first[3], 32'(-1));
    checkOutput("t3_ch_never", 32'(ch1_high + ch2_high), 0);
    checkOutput("t3_busy_after", busy_at[7], 0);

    // Channel 2 run for 21 XFER cycles.
    $display("[TB] channel 2 transfer");
    runTxn(2'b01, 1'b1, 0, 0, 0, 29);
    checkOutput("t4_ch2_rise", ch2_first, 9);
    checkOutput("t4_ch2_held", ch2_high, 21);
    checkOutput("t4_ch1_never", ch1_high, 0);
    checkOutput("t4_arm_sel", sel_at[8], 1);
    checkOutput("t4_fetch_sel", sel_at[7], 2);
    checkOutput("t4_con_en_count", con_en_count, 1);
    drainTxn(2'b00, 1'b1);

    // Request changes during XFER; picked up only once back in IDLE.
    $display("[TB] request change while busy");
    runTxn(2'b01, 1'b0, 0, 0, 0, 12);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b10, 1'b1, 2'b00, 1'b0, 1'b0);
      checkOutput("t5_no_relatch", 32'(bus.DmacReq_Reg_en), 0);
    end
    drainTxn(2'b10, 1'b0);
    applyStimulus(2'b10, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("t5_relatch", 32'(bus.DmacReq_Reg_en), 1);
    repeat (8) applyStimulus(2'b10, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("t5_ch1_again", 32'(bus.channel_en_1), 1);
    drainTxn(2'b00, 1'b0);

    // Asynchronous reset in the middle of the fetch.
    $display("[TB] reset mid-fetch");
    runTxn(2'b01, 1'b0, 0, 0, 0, 4);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    bus.DmacReq = 2'b00;
    checkOutput("t6_busy", 32'(bus.busy), 0);
    checkOutput("t6_htrans", 32'(bus.config_HTrans), 0);
    checkOutput("t6_addr_sel", 32'(bus.addr_inc_sel), 0);
    checkOutput("t6_capture", 32'({bus.Ctrl_Reg_en, bus.Trans_sz_Reg_en,
                bus.DAddr_Reg_en, bus.SAddr_Reg_en}), 0);
    checkOutput("t6_con_sel", 32'(bus.con_sel), 2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
      checkOutput("t6_idle", 32'({bus.busy, bus.DmacReq_Reg_en}), 0);
    end

    // Random traffic.
    $display("[TB] random traffic");
    hold = 0;
    req  = 2'b00;
    cc   = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      if (hold == 0) begin
        req  = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        hold = $urandom_range(1, 30);
      end else begin
        hold--;
      end
      if (!bus.busy) cc = 1'($urandom_range(0, 1));
      applyStimulus(req, 1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 40) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    cc, 1'($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
